// File: rtl/user_wb_pkg.sv
// Shared types and constants for the user-area Wishbone fabric.
package user_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_e;

    typedef enum logic {
        CAUSE_UNMAPPED = 1'b0,
        CAUSE_TIMEOUT  = 1'b1
    } err_cause_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          SLOT_W           = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/user_wb_fabric_watchdog.sv
// Per-transaction watchdog: counts enabled cycles, flags terminal count at TIMEOUT.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tc_o = (cnt_q == 16'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/user_wb_fabric.sv
// Fans the management-SoC Wishbone port out to NUM_SLAVES user blocks,
// answering unmapped and timed-out accesses with an error response.
module user_wb_fabric
    import user_wb_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int          SLAVE_AW   = 20,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = DEFAULT_ERR_DATA
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_SLAVES-1:0]    m_cyc_o,
    output logic [NUM_SLAVES-1:0]    m_stb_o,
    output logic                     m_we_o,
    output logic [3:0]               m_sel_o,
    output logic [SLAVE_AW-1:0]      m_adr_o,
    output logic [31:0]              m_dat_o,
    input  logic [32*NUM_SLAVES-1:0] m_dat_i,
    input  logic [NUM_SLAVES-1:0]    m_ack_i,
    input  logic                     irq_clr_i,
    output logic                     timeout_irq_o,
    output logic [7:0]               err_count_o
);

    state_e                  state_q;
    err_cause_e              cause_q;
    logic [SLOT_W-1:0]       slot_q;
    logic                    ack_q;
    logic [31:0]             rdat_q;
    logic [NUM_SLAVES-1:0]   cyc_q;
    logic [NUM_SLAVES-1:0]   stb_q;
    logic                    we_q;
    logic [3:0]              sel_q;
    logic [SLAVE_AW-1:0]     adr_q;
    logic [31:0]             wdat_q;
    logic                    irq_q;
    logic [7:0]              err_cnt_q;

    logic [31:0]             off;
    logic [31:0]             slot_w;
    logic                    addr_ok;
    logic [SLOT_W-1:0]       slot_n;
    logic [NUM_SLAVES-1:0]   slot_oh;
    logic                    ack_hit;
    logic [31:0]             rd_mux;
    logic                    wd_tc;
    logic                    irq_set;

    assign off     = wbs_adr_i - ADDR_BASE;
    assign slot_w  = off >> SLAVE_AW;
    assign addr_ok = (wbs_adr_i >= ADDR_BASE) && (slot_w < 32'(NUM_SLAVES));
    assign slot_n  = slot_w[SLOT_W-1:0];

    always_comb begin
        slot_oh = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (slot_n == SLOT_W'(k)) begin
                slot_oh[k] = 1'b1;
            end
        end
    end

    // Only the latched slot's ack and data are observed.
    always_comb begin
        ack_hit = 1'b0;
        rd_mux  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                ack_hit = m_ack_i[k];
                rd_mux  = m_dat_i[32*k +: 32];
            end
        end
    end

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .clr_i (state_q != FWD),
        .en_i  (state_q == FWD),
        .tc_o  (wd_tc)
    );

    assign irq_set = (state_q == ERR) && (cause_q == CAUSE_TIMEOUT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cause_q   <= CAUSE_UNMAPPED;
            slot_q    <= '0;
            ack_q     <= 1'b0;
            rdat_q    <= '0;
            cyc_q     <= '0;
            stb_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            irq_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
            unique case (state_q)
                IDLE: begin
                    // The ack cycle of an error response is spent in IDLE;
                    // the master still holds stb then, so do not re-accept.
                    if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
                        we_q   <= wbs_we_i;
                        sel_q  <= wbs_sel_i;
                        adr_q  <= off[SLAVE_AW-1:0];
                        wdat_q <= wbs_dat_i;
                        slot_q <= slot_n;
                        if (addr_ok) begin
                            cyc_q   <= slot_oh;
                            stb_q   <= slot_oh;
                            state_q <= FWD;
                        end else begin
                            cause_q <= CAUSE_UNMAPPED;
                            state_q <= ERR;
                        end
                    end
                end
                FWD: begin
                    if (!wbs_cyc_i) begin
                        cyc_q   <= '0;
                        stb_q   <= '0;
                        state_q <= IDLE;
                    end else if (ack_hit) begin
                        cyc_q   <= '0;
                        stb_q   <= '0;
                        ack_q   <= 1'b1;
                        rdat_q  <= we_q ? 32'h0 : rd_mux;
                        state_q <= RESP;
                    end else if (wd_tc) begin
                        cyc_q   <= '0;
                        stb_q   <= '0;
                        cause_q <= CAUSE_TIMEOUT;
                        state_q <= ERR;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                ERR: begin
                    ack_q     <= 1'b1;
                    rdat_q    <= ERR_DATA;
                    err_cnt_q <= sat_inc8(err_cnt_q);
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (irq_set) begin
                irq_q <= 1'b1;
            end else if (irq_clr_i) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = rdat_q;
    assign m_cyc_o       = cyc_q;
    assign m_stb_o       = stb_q;
    assign m_we_o        = we_q;
    assign m_sel_o       = sel_q;
    assign m_adr_o       = adr_q;
    assign m_dat_o       = wdat_q;
    assign timeout_irq_o = irq_q;
    assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_user_wb_fabric.sv
// Scoreboard bench for user_wb_fabric: slave model driven per transfer.
module tb_user_wb_fabric;

    localparam int NS  = 4;
    localparam int TMO = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       adr, wdat;
    logic              ack;
    logic [31:0]       rdat;
    logic [NS-1:0]     m_cyc, m_stb;
    logic              m_we;
    logic [3:0]        m_sel;
    logic [19:0]       m_adr;
    logic [31:0]       m_wdat;
    logic [32*NS-1:0]  m_rdat;
    logic [NS-1:0]     m_ack;
    logic              irq_clr;
    logic              irq;
    logic [7:0]        errc;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          tests  = 0;
    int          failed = 0;
    int          err_m  = 0;
    int          stb_cycles;
    bit          cap_valid;
    logic [19:0] cap_adr;
    logic [31:0] cap_dat;
    logic        cap_we;
    logic [3:0]  cap_sel;

    always #5 clk = ~clk;

    user_wb_fabric #(
        .NUM_SLAVES (NS),
        .ADDR_BASE  (32'h3000_0000),
        .SLAVE_AW   (20),
        .TIMEOUT    (TMO),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat),
        .m_cyc_o       (m_cyc),
        .m_stb_o       (m_stb),
        .m_we_o        (m_we),
        .m_sel_o       (m_sel),
        .m_adr_o       (m_adr),
        .m_dat_o       (m_wdat),
        .m_dat_i       (m_rdat),
        .m_ack_i       (m_ack),
        .irq_clr_i     (irq_clr),
        .timeout_irq_o (irq),
        .err_count_o   (errc)
    );

    // Cycle 0 is the cycle the request is presented; k counts cycles after it.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int tgt, input int ack_cyc, input logic [31:0] rd,
                        input logic [NS-1:0] noise, input int abort_cyc,
                        input logic [31:0] exp_d, input int exp_lat);
        exp_t          e, got;
        logic [NS-1:0] seen_stb, seen_cyc, want;
        bit            done;
        e.data = exp_d;
        e.lat  = exp_lat;
        want = (tgt >= 0) ? NS'(1 << tgt) : '0;
        @(negedge clk);
        adr = a; we = w; wdat = d; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        if (abort_cyc == 0) sb.push_back(e);
        seen_stb = '0; seen_cyc = '0; stb_cycles = 0; cap_valid = 0; done = 0;
        for (int k = 1; k <= 600 && !done; k++) begin
            @(negedge clk);
            seen_stb |= m_stb;
            seen_cyc |= m_cyc;
            if (m_stb != '0) begin
                stb_cycles++;
                if (!cap_valid) begin
                    cap_valid = 1; cap_adr = m_adr; cap_dat = m_wdat;
                    cap_we = m_we; cap_sel = m_sel;
                end
            end
            m_ack = '0;
            if (ack) begin
                done = 1; cyc = 1'b0; stb = 1'b0;
                if (sb.size() == 0) begin
                    tests++; failed++;
                    $display("FAIL unexpected_ack adr=%h cycle=%0d", a, k);
                end else begin
                    got = sb.pop_front();
                    tests++;
                    if (rdat !== got.data) begin
                        failed++;
                        $display("FAIL data adr=%h got=%h want=%h", a, rdat, got.data);
                    end
                    tests++;
                    if (k !== got.lat) begin
                        failed++;
                        $display("FAIL latency adr=%h got=%0d want=%0d", a, k, got.lat);
                    end
                end
            end else if (abort_cyc != 0 && k == abort_cyc) begin
                done = 1; cyc = 1'b0; stb = 1'b0;
            end else begin
                m_ack = noise;
                if (tgt >= 0 && k == ack_cyc) m_ack[tgt] = 1'b1;
                for (int j = 0; j < NS; j++)
                    m_rdat[32*j +: 32] = (j == tgt) ? rd : (32'h0BAD_0000 | 32'(j));
            end
        end
        m_ack = '0;
        if (!done) begin
            tests++; failed++;
            $display("FAIL no_response adr=%h got=none want=ack", a);
            cyc = 1'b0; stb = 1'b0;
            if (sb.size() != 0) void'(sb.pop_front());
        end
        tests++;
        if (seen_stb !== want || seen_cyc !== want) begin
            failed++;
            $display("FAIL strobes adr=%h got_stb=%b got_cyc=%b want=%b",
                     a, seen_stb, seen_cyc, want);
        end
    endtask

    task automatic chk_err(input string nm);
        tests++;
        if (errc !== 8'(err_m)) begin
            failed++;
            $display("FAIL %s err_count got=%0d want=%0d", nm, errc, err_m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        m_ack = '0; m_rdat = '0; irq_clr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (ack !== 1'b0) begin failed++; $display("FAIL rst_ack got=%b want=0", ack); end
        tests++; if (rdat !== 32'h0) begin failed++; $display("FAIL rst_dat got=%h want=0", rdat); end
        tests++; if (m_stb !== '0 || m_cyc !== '0) begin
            failed++; $display("FAIL rst_strobes got=%b/%b want=0", m_stb, m_cyc); end
        tests++; if (m_adr !== '0 || m_wdat !== '0 || m_we !== 1'b0) begin
            failed++; $display("FAIL rst_mbus got=%h/%h/%b want=0", m_adr, m_wdat, m_we); end
        tests++; if (irq !== 1'b0) begin failed++; $display("FAIL rst_irq got=%b want=0", irq); end
        chk_err("rst");
    endtask

    task automatic test_write();
        xfer(32'h3010_0004, 1'b1, 32'h1234_5678, 1, 3, 32'h0, '0, 0, 32'h0, 4);
        tests++; if (cap_adr !== 20'h4) begin failed++; $display("FAIL wr_adr got=%h want=4", cap_adr); end
        tests++; if (cap_dat !== 32'h1234_5678 || cap_we !== 1'b1 || cap_sel !== 4'hF) begin
            failed++; $display("FAIL wr_bus got=%h/%b/%h want=12345678/1/f", cap_dat, cap_we, cap_sel); end
        tests++; if (stb_cycles !== 3) begin failed++; $display("FAIL wr_stb_len got=%0d want=3", stb_cycles); end
        @(negedge clk);
        tests++; if (ack !== 1'b0) begin failed++; $display("FAIL ack_one_cycle got=%b want=0", ack); end
    endtask

    task automatic test_read();
        xfer(32'h3030_0010, 1'b0, 32'h0, 3, 1, 32'hCAFE_F00D, '0, 0, 32'hCAFE_F00D, 2);
        tests++; if (cap_adr !== 20'h10 || cap_we !== 1'b0) begin
            failed++; $display("FAIL rd_bus got=%h/%b want=10/0", cap_adr, cap_we); end
        xfer(32'h303F_FFFC, 1'b0, 32'h0, 3, 2, 32'h7777_0003, '0, 0, 32'h7777_0003, 3);
        tests++; if (cap_adr !== 20'hFFFFC) begin failed++; $display("FAIL top_adr got=%h want=ffffc", cap_adr); end
        xfer(32'h3000_0000, 1'b0, 32'h0, 0, 1, 32'h0000_BA5E, '0, 0, 32'h0000_BA5E, 2);
    endtask

    task automatic test_unmapped();
        xfer(32'h3040_0000, 1'b0, 32'h0, -1, 0, 32'h0, '0, 0, 32'hDEAD_BEEF, 2);
        err_m++; chk_err("slot4");
        xfer(32'h2FFF_FFFC, 1'b1, 32'h5555_AAAA, -1, 0, 32'h0, '0, 0, 32'hDEAD_BEEF, 2);
        err_m++; chk_err("below_base");
        tests++; if (irq !== 1'b0) begin failed++; $display("FAIL unmapped_irq got=%b want=0", irq); end
    endtask

    task automatic test_foreign_ack();
        xfer(32'h3020_0008, 1'b0, 32'h0, 2, 4, 32'h5A5A_1234, 4'b1011, 0, 32'h5A5A_1234, 5);
    endtask

    task automatic test_timeout();
        xfer(32'h3000_0000, 1'b0, 32'h0, 0, 0, 32'h0, '0, 0, 32'hDEAD_BEEF, TMO + 3);
        err_m++; chk_err("timeout");
        tests++; if (stb_cycles !== TMO + 1) begin
            failed++; $display("FAIL tmo_stb_len got=%0d want=%0d", stb_cycles, TMO + 1); end
        tests++; if (irq !== 1'b1) begin failed++; $display("FAIL tmo_irq got=%b want=1", irq); end
        xfer(32'h3000_0100, 1'b0, 32'h0, 0, TMO + 1, 32'hA5A5_0001, '0, 0, 32'hA5A5_0001, TMO + 2);
        chk_err("ack_wins");
        tests++; if (irq !== 1'b1) begin failed++; $display("FAIL irq_sticky got=%b want=1", irq); end
        @(negedge clk); irq_clr = 1'b1;
        @(negedge clk); irq_clr = 1'b0;
        tests++; if (irq !== 1'b0) begin failed++; $display("FAIL irq_clr got=%b want=0", irq); end
    endtask

    task automatic test_abort();
        bit bad_ack;
        xfer(32'h3020_0000, 1'b0, 32'h0, 2, 0, 32'h0, '0, 100, 32'h0, 0);
        @(negedge clk);
        tests++; if (m_stb !== '0 || m_cyc !== '0) begin
            failed++; $display("FAIL abort_strobes got=%b/%b want=0", m_stb, m_cyc); end
        bad_ack = ack;
        repeat (3) begin @(negedge clk); bad_ack |= ack; end
        tests++; if (bad_ack !== 1'b0) begin failed++; $display("FAIL abort_ack got=1 want=0"); end
        chk_err("abort");
        xfer(32'h3020_0000, 1'b0, 32'h0, 2, 200, 32'h1357_9BDF, '0, 0, 32'h1357_9BDF, 201);
        chk_err("post_abort");
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [4] = '{32'h3010_0020, 32'h3070_0000, 32'h3030_0004, 32'h3000_0008};
        int          tt [4] = '{1, -1, 3, 0};
        logic [31:0] td [4] = '{32'h1111_2222, 32'h0, 32'h3333_4444, 32'h5555_6666};
        for (int i = 0; i < 4; i++) begin
            if (tt[i] < 0) begin
                xfer(ta[i], 1'b0, 32'h0, -1, 0, 32'h0, '0, 0, 32'hDEAD_BEEF, 2);
                err_m++;
            end else begin
                xfer(ta[i], 1'b0, 32'h0, tt[i], i + 1, td[i], '0, 0, td[i], i + 2);
            end
        end
        chk_err("b2b");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            xfer(32'h3050_0000 + 32'(i * 4), 1'b0, 32'h0, -1, 0, 32'h0, '0, 0, 32'hDEAD_BEEF, 2);
            if (err_m < 255) err_m++;
        end
        chk_err("saturate");
    endtask

    task automatic test_reset_mid();
        bit bad_ack;
        @(negedge clk);
        adr = 32'h3010_0000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (m_stb !== 4'b0010) begin failed++; $display("FAIL mid_stb got=%b want=0010", m_stb); end
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        tests++; if (m_stb !== '0 || m_cyc !== '0 || ack !== 1'b0) begin
            failed++; $display("FAIL mid_rst got=%b/%b/%b want=0", m_stb, m_cyc, ack); end
        rst = 1'b0;
        bad_ack = 0;
        repeat (4) begin @(negedge clk); bad_ack |= ack; end
        tests++; if (bad_ack !== 1'b0) begin failed++; $display("FAIL mid_ack got=1 want=0"); end
        tests++; if (sb.size() !== 0) begin failed++; $display("FAIL sb_left got=%0d want=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unmapped();
        test_foreign_ack();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=hang want=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
